// File: rtl/stencil3x3_sum_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : stencil3x3_sum_stream_if
// Purpose  : Pixel-in / window-sum-out stream bundle for the 3x3 stencil.
// Revision : 1.0
// ============================================================================
interface stencil3x3_sum_stream_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             mode;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             frame_done;

  modport master (
    output in_valid, in_data, mode,
    input  out_valid, out_data, frame_done
  );

  modport slave (
    input  in_valid, in_data, mode,
    output out_valid, out_data, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/stencil3x3_sum_stream.sv
`default_nettype none
// ============================================================================
// Module   : stencil3x3_sum_stream
// Purpose  : Streaming 3x3 box sum over a raster image, wrapping or saturating.
// Revision : 1.0
// ============================================================================
module stencil3x3_sum_stream #(
  parameter int WIDTH = 16,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  wire                            clk,
  input  wire                            reset,
  stencil3x3_sum_stream_if.slave         s
);

  localparam int c_CW = $clog2(IMG_W);
  localparam int c_RW = $clog2(IMG_H);
  localparam int c_SW = WIDTH + 4;
  localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);
  localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
  localparam logic [c_RW-1:0] c_ROW_TWO  = c_RW'(2);

  logic [c_CW-1:0]  r_col;
  logic [c_RW-1:0]  r_row;
  logic [WIDTH-1:0] r_line0 [IMG_W];
  logic [WIDTH-1:0] r_line1 [IMG_W];
  logic [WIDTH-1:0] r_win   [3][3];
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_frame_done;

  logic             w_accept;
  logic             w_complete;
  logic             w_col_last;
  logic             w_row_last;
  logic [WIDTH-1:0] w_l0;
  logic [WIDTH-1:0] w_l1;
  logic [c_SW-1:0]  w_sum;
  logic [WIDTH-1:0] w_res;

  assign w_accept   = s.in_valid && !reset;
  assign w_col_last = (r_col == c_COL_LAST);
  assign w_row_last = (r_row == c_ROW_LAST);
  assign w_complete = (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);
  assign w_l0       = r_line0[r_col];
  assign w_l1       = r_line1[r_col];

  // The incoming column is summed directly, so the result registers one edge after acceptance.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < 3; k++) begin
      w_sum = w_sum + {4'b0000, r_win[k][1]} + {4'b0000, r_win[k][2]};
    end
    w_sum = w_sum + {4'b0000, w_l1} + {4'b0000, w_l0} + {4'b0000, s.in_data};
    if (s.mode && (|w_sum[c_SW-1:WIDTH])) begin
      w_res = '1;
    end else begin
      w_res = w_sum[WIDTH-1:0];
    end
  end

  // Line buffers are never cleared: row>=2 gating keeps stale entries out of results.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line0[r_col] <= s.in_data;
      r_line1[r_col] <= w_l0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (s.in_valid) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_l1;
        r_win[1][2] <= w_l0;
        r_win[2][2] <= s.in_data;

        if (w_complete) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= w_res;
          r_frame_done <= w_col_last && w_row_last;
        end

        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign s.out_valid  = r_out_valid;
  assign s.out_data   = r_out_data;
  assign s.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_stencil3x3_sum_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_stencil3x3_sum_stream
// Purpose  : Self-checking bench: frame table, corner sequences, random frames.
// Revision : 1.0
// ============================================================================
module tb_stencil3x3_sum_stream;

  localparam int W  = 16;
  localparam int IW = 4;
  localparam int IH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stencil3x3_sum_stream_if #(.WIDTH(W)) bus ();

  stencil3x3_sum_stream #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model: a plain image array plus raster position.
  int img [IH][IW];
  int mcol, mrow;
  int ev, ed, efd;

  int obs_data[$];
  int obs_fd[$];
  int fd_count;

  typedef struct {
    string name;
    int    ramp;
    int    fill;
    int    mode;
    int    exp_res[4];
  } frame_vec_t;

  frame_vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic model(input int v, input int d, input int m, input int rs);
    int sum;
    if (rs != 0) begin
      mcol = 0; mrow = 0; ev = 0; ed = 0; efd = 0;
    end else begin
      ev = 0; efd = 0;
      if (v != 0) begin
        img[mrow][mcol] = d;
        if (mrow >= 2 && mcol >= 2) begin
          sum = 0;
          for (int r = mrow - 2; r <= mrow; r++)
            for (int c = mcol - 2; c <= mcol; c++)
              sum += img[r][c];
          ed  = (m != 0) ? ((sum > 65535) ? 65535 : sum) : (sum % 65536);
          ev  = 1;
          efd = (mrow == IH - 1 && mcol == IW - 1) ? 1 : 0;
        end
        if (mcol == IW - 1) begin
          mcol = 0;
          mrow = (mrow == IH - 1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
      end
    end
  endtask

  task automatic step(input int v, input int d, input int m, input int rs);
    @(negedge clk);
    reset        = rs[0];
    bus.in_valid = v[0];
    bus.in_data  = d[W-1:0];
    bus.mode     = m[0];
    @(posedge clk);
    model(v, d, m, rs);
    #1;
    check("out_valid",  int'(bus.out_valid),  ev);
    check("out_data",   int'(bus.out_data),   ed);
    check("frame_done", int'(bus.frame_done), efd);
    if (bus.out_valid) begin
      obs_data.push_back(int'(bus.out_data));
      obs_fd.push_back(int'(bus.frame_done));
    end
    if (bus.frame_done) fd_count++;
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_fd.delete();
    fd_count = 0;
  endtask

  task automatic ramp_frame(input int gaps);
    int i;
    i = 0;
    while (i < IW * IH) begin
      if (gaps != 0 && $urandom_range(0, 1) == 0) begin
        step(0, int'($urandom_range(0, 65535)), 0, 0);
      end else begin
        step(1, i, 0, 0);
        i++;
      end
    end
  endtask

  task automatic check_ramp_results(input string tag, input int frames);
    int exp[4];
    exp = '{45, 54, 81, 90};
    check({tag, " count"}, obs_data.size(), 4 * frames);
    for (int k = 0; k < obs_data.size() && k < 4 * frames; k++) begin
      check({tag, " result"}, obs_data[k], exp[k % 4]);
      check({tag, " fd"}, obs_fd[k], (k % 4 == 3) ? 1 : 0);
    end
    check({tag, " fd pulses"}, fd_count, frames);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode     = 1'b0;
    fd_count     = 0;
    mcol = 0; mrow = 0; ev = 0; ed = 0; efd = 0;

    vecs[0] = '{"all_ones",      0, 1,       0, '{9, 9, 9, 9}};
    vecs[1] = '{"ramp",          1, 0,       0, '{45, 54, 81, 90}};
    vecs[2] = '{"sat_2000",      0, 'h2000,  1, '{'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF}};
    vecs[3] = '{"wrap_2000",     0, 'h2000,  0, '{'h2000, 'h2000, 'h2000, 'h2000}};

    step(1, 'h1234, 0, 1);
    step(0, 0, 0, 1);
    check("reset out_valid",  int'(bus.out_valid),  0);
    check("reset out_data",   int'(bus.out_data),   0);
    check("reset frame_done", int'(bus.frame_done), 0);

    for (int v = 0; v < 4; v++) begin
      clear_obs();
      for (int i = 0; i < IW * IH; i++)
        step(1, (vecs[v].ramp != 0) ? i : vecs[v].fill, vecs[v].mode, 0);
      step(0, 0, 0, 0);
      check({vecs[v].name, " count"}, obs_data.size(), 4);
      for (int k = 0; k < 4 && k < obs_data.size(); k++) begin
        check({vecs[v].name, " result"}, obs_data[k], vecs[v].exp_res[k]);
        check({vecs[v].name, " fd"}, obs_fd[k], (k == 3) ? 1 : 0);
      end
      check({vecs[v].name, " fd pulses"}, fd_count, 1);
    end

    // Ramp with random idle cycles.
    clear_obs();
    ramp_frame(1);
    step(0, 0, 0, 0);
    check_ramp_results("gapped ramp", 1);

    // Aborted partial frame, then a clean frame.
    clear_obs();
    for (int i = 0; i < 6; i++) step(1, 100 + i, 0, 0);
    step(1, 7, 0, 1);
    ramp_frame(0);
    step(0, 0, 0, 0);
    check_ramp_results("abort then ramp", 1);

    // Two frames back to back, no idle.
    clear_obs();
    ramp_frame(0);
    ramp_frame(0);
    step(0, 0, 0, 0);
    check_ramp_results("back to back", 2);

    // Random pixels, modes and gaps, with occasional large values and rare resets.
    for (int n = 0; n < 1500; n++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(50000, 65535))
                                      : int'($urandom_range(0, 65535));
      step(($urandom_range(0, 3) != 0) ? 1 : 0, d, int'($urandom_range(0, 1)),
           ($urandom_range(0, 199) == 0) ? 1 : 0);
    end
    step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stencil3x3_sum_stream.md
STENCIL3X3_SUM_STREAM -- requirements
Module: stencil3x3_sum_stream

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the pixel and result bit width (>=1).
REQ-002 The block SHALL take parameter IMG_W, default 64, as the pixels per row (>=3).
REQ-003 The block SHALL take parameter IMG_H, default 64, as the rows per frame (>=3).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data carries a pixel this cycle; no backpressure.
REQ-007 in_data  input  WIDTH  unsigned pixel, raster order, row-major.
REQ-008 mode  input  1  0 = wrapping sum, 1 = saturating sum; sampled with each accepted pixel.
REQ-009 out_valid  output  1  out_data holds a valid 3x3 window result.
REQ-010 out_data  output  WIDTH  unsigned 9-tap sum.
REQ-011 frame_done  output  1  one-cycle pulse coincident with the last result of a frame.

Function
REQ-012 The block SHALL accept a pixel on every cycle with in_valid=1; cycles with in_valid=0 SHALL change no state except clearing out_valid/frame_done.
REQ-013 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL give the position of the accepted pixel; col wraps to 0 and row increments at col=IMG_W-1; both wrap to 0 after (IMG_W-1, IMG_H-1).
REQ-014 Two line buffers of depth IMG_W SHALL hold the previous two rows; each accepted pixel is written to line 0 while the evicted line-0 value moves into line 1.
REQ-015 A 3x3 window register SHALL shift one column per accepted pixel, loading column {line1 out, line0 out, in_data}.
REQ-016 A window SHALL be complete when the accepted pixel has row>=2 and col>=2; it covers rows row-2..row, cols col-2..col.
REQ-017 For a complete window, out_valid SHALL be 1 and out_data SHALL hold the result exactly one cycle after the accepting edge (latency 1); otherwise out_valid SHALL be 0.
REQ-018 Sum SHALL be computed at WIDTH+4 bits; mode 0 outputs the low WIDTH bits; mode 1 outputs 2^WIDTH-1 when the full sum exceeds it.
REQ-019 Windows SHALL never straddle row or frame boundaries; exactly (IMG_W-2)*(IMG_H-2) results per frame.
REQ-020 frame_done SHALL be 1 in the same cycle as the result for pixel (IMG_W-1, IMG_H-1), else 0.
REQ-021 Back-to-back frames SHALL need no idle cycles; stale line-buffer contents are masked by the row>=2 gating.
REQ-022 out_data SHALL hold its last value while out_valid=0.

Reset
REQ-023 On reset=1 at a rising edge: col=0, row=0, out_valid=0, frame_done=0, out_data=0, window registers=0; in_valid is ignored that cycle.
REQ-024 Line-buffer contents need not be cleared; no output SHALL depend on them before being rewritten.
REQ-025 Reset mid-frame SHALL abandon the frame; the next accepted pixel is treated as (0,0).

Verification (WIDTH=16, IMG_W=4, IMG_H=4)
REQ-026 16 pixels all 1, mode 0, continuous -> 4 results of 9, last with frame_done=1.
REQ-027 Pixels 0..15 ramp, mode 0 -> results 45, 54, 81, 90 in order, each 1 cycle after pixels 10, 11, 14, 15.
REQ-028 All pixels 16'h2000 -> mode 1 gives 16'hFFFF; mode 0 gives 16'h2000.
REQ-029 Ramp with in_valid random 50% gaps -> same 4 results; out_valid never 1 for two cycles per accepted pixel.
REQ-030 6 ramp pixels, reset 1 cycle, then full ramp frame -> exactly 45, 54, 81, 90; no output from the aborted frame.
REQ-031 Two ramp frames back-to-back -> 8 results, frame_done pulses exactly twice.
